sink_capture_ctrl: RTL

SINK_CAPTURE_CTRL -- requirements
Module: sink_capture_ctrl

---
 rtl/sink_capture_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/sink_capture_ctrl.sv
// Capture controller: reads N_CH lockstep FIFOs and writes the returned
// samples into a capture memory, one-shot or as a circular buffer.
module sink_capture_ctrl #(
   parameter int ADDR_WIDTH = 20,
   parameter int N_CH       = 2,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  nop,
   input  logic                  mode_i,
   input  logic [N_CH-1:0]       Empty_i,
   input  logic [ADDR_WIDTH-1:0] ilen,
   output logic                  Read_Enable_o,
   output logic                  Write_Enable_o,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  done,
   output logic                  busy,
   output logic                  wrap_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   len;
   logic                    circ;
   logic [ADDR_WIDTH-1:0]   rd_cnt;
   logic [ADDR_WIDTH-1:0]   wr_cnt;
   logic [RD_LAT-1:0]       pipe;
   logic                    re;
   logic                    we;

   // Read strobe: any empty channel, nop or abort blocks the read this cycle.
   always_comb begin
      re = (state == RUN) & ~nop & ~abort_i & (Empty_i == '0) & (rd_cnt < len);
   end

   // The data returned by a read lands RD_LAT cycles later; the write follows it.
   assign we             = pipe[RD_LAT-1];
   assign Read_Enable_o  = re;
   assign Write_Enable_o = we;
   assign addr           = wr_cnt;
   assign wrap_o         = we & circ & (wr_cnt == len - ONE);

   // Control FSM, counters, read-latency pipeline and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         len    <= '0;
         circ   <= 1'b0;
         rd_cnt <= '0;
         wr_cnt <= '0;
         pipe   <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         // Reads already issued always complete, whatever nop/abort do later.
         pipe[0] <= re;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];

         if (start_i && state != IDLE) err_o <= 1'b1;

         if (re) rd_cnt <= (circ && rd_cnt == len - ONE) ? '0 : rd_cnt + ONE;
         if (we) wr_cnt <= (circ && wr_cnt == len - ONE) ? '0 : wr_cnt + ONE;

         case (state)
            IDLE: begin
               if (start_i) begin
                  len    <= ilen;
                  circ   <= mode_i;
                  rd_cnt <= '0;
                  wr_cnt <= '0;
                  busy   <= 1'b1;
                  if (ilen == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               // Circular capture only ends on abort; one-shot ends once all reads issued.
               if (abort_i || (!circ && rd_cnt == len)) state <= DRAIN;
            end
            DRAIN: begin
               if (pipe == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
